adder_accum: RTL

ADDER_ACCUM -- requirements
Module: adder_accum

---
 rtl/adder_accum.sv | 131 +++++++++++++
 1 files changed

// File: rtl/adder_accum.sv
// adder_accum -- beat accumulator with a valid/ready handshake on each side.
//
// Sums zero-extended 8-bit beats into an ACC_W-bit accumulator. A vector closes
// when VEC_LEN beats have been accepted or when a beat carries in_last,
// whichever comes first. The result is then held until downstream takes it.
//
// Parameters:
//   VEC_LEN  beats per vector (1..256)
//   ACC_W    accumulator / result width (9..32)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream beat valid
//   in_ready   beat accepted this cycle (ACCUM state, not in reset)
//   in_data    8-bit unsigned operand
//   in_last    beat closes the vector early
//   out_valid  result held for downstream (HOLD state)
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum
//   out_count  beats in the vector
//   out_ovf    sticky overflow flag for the vector
//
// Compile-time option:
//   ADDER_ACCUM_SATURATE_EN  clamp the accumulator at 2^ACC_W-1 on overflow
//                            instead of wrapping; out_ovf is set either way.

module adder_accum #(
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [8:0]       out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [8:0] LP_VEC_LEN = 9'(VEC_LEN);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [8:0]       r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_close;
    logic             w_release;
    logic [ACC_W:0]   w_sum_ext;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic [8:0]       w_cnt_inc;

    assign w_accept  = in_valid && in_ready;
    assign w_release = (r_state == HOLD) && out_ready;
    assign w_cnt_inc = r_cnt + 9'd1;
    // Reaching VEC_LEN and in_last on the same beat close a single vector.
    assign w_close   = w_accept && (in_last || (w_cnt_inc == LP_VEC_LEN));

    // One extra bit captures the carry out of the accumulator MSB.
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, in_data};
    assign w_carry   = w_sum_ext[ACC_W];

`ifdef ADDER_ACCUM_SATURATE_EN
    // Once clamped, any nonzero beat carries again, so the value stays clamped.
    assign w_acc_next = w_carry ? '1 : w_sum_ext[ACC_W-1:0];
`else
    assign w_acc_next = w_sum_ext[ACC_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ACCUM: if (w_close)   w_state_next = HOLD;
            HOLD:  if (w_release) w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    // Output logic; handshakes are masked while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            in_ready  = (r_state == ACCUM);
            out_valid = (r_state == HOLD);
        end
    end

    // Datapath: accumulator, beat counter, sticky overflow
    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_inc;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule
